ifu_prefetch_buf: RTL and testbench
===================================

# ifu_prefetch_buf

Parametrised instruction prefetch buffer between the core's instruction-fetch bus (req/gnt/rvalid) and the decode stage. Keeps up to `MAX_OUTSTANDING` fetches in flight and up to `DEPTH` fetched words buffered, so the fetch stream is decoupled from decode back-pressure. Redirects on flush, discarding stale responses, and halts fetching after a bus error. Successor to the single-outstanding fetch path; both depth and outstanding count are configurable.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2: maximum granted-but-unanswered requests; 1..DEPTH.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush_i` in 1: redirect request.
- `flush_addr_i` in 32: redirect target; bits [1:0] are ignored and forced to 0.
- `instr_req_o` out 1: fetch request.
- `instr_addr_o` out 32: fetch address, word-aligned.
- `instr_gnt_i` in 1: request accepted this cycle.
- `instr_rvalid_i` in 1: response valid. Responses return in order.
- `instr_rdata_i` in 32: response data.
- `instr_err_i` in 1: response error; qualified by `instr_rvalid_i`.
- `out_valid_o` out 1: FIFO head is valid.
- `out_ready_i` in 1: consumer pops the head when `out_valid_o` is also high.
- `out_inst_o` out 32: head instruction.
- `out_pc_o` out 32: head PC.
- `out_err_o` out 1: head is a bus-error entry.
- `busy_o` out 1: outstanding count ≠ 0 or discard count ≠ 0.

## Operation
- **Registered state:**
  - `fetch_addr`: next address to request.
  - `rsp_pc`: PC of the next kept response.
  - `outst`: outstanding count.
  - `discard`: responses still to be dropped.
  - FIFO of {inst, pc, err} with `count`.
  - `halted` flag.
- **Issue:** `instr_req_o` = !halted && outst < MAX_OUTSTANDING && (count + outst) < DEPTH; `instr_addr_o` = fetch_addr.
  - The credit rule guarantees FIFO overflow is impossible.
- **Request stability:** once `instr_req_o` is high, `instr_req_o` and `instr_addr_o` are held unchanged until `instr_gnt_i`. This holds across flush: a pending ungranted request completes, and its response is discarded.
- **Grant:** `fetch_addr` += 4 (wraps modulo 2^32) and `outst` += 1.
- **Response:** `outst` -= 1.
  - If `discard` > 0: `discard` -= 1 and the data is dropped.
  - Otherwise: push {rdata, rsp_pc, err} and `rsp_pc` += 4.
- **Error:** a kept response with `instr_err_i` = 1 sets `halted`. No further requests are issued until flush. Entries already in flight are still queued behind the error entry.
- **Pop:** `out_valid_o` && `out_ready_i` removes the head. Push and pop in the same cycle are allowed, including when the FIFO is full or empty (count unchanged).
- **Flush (highest priority):**
  - FIFO cleared.
  - `halted` cleared.
  - `fetch_addr` and `rsp_pc` set to {flush_addr_i[31:2], 2'b00}. If a request is pending ungranted, `fetch_addr` is loaded only after that request's grant.
  - `discard` = outst + gnt − rvalid, all same-cycle values. A response arriving in the flush cycle is dropped, and a grant in the flush cycle is counted as stale.
  - Pop and push in the flush cycle are ignored.
- **Ordering:** `out_pc_o` sequence is strictly +4 between flushes.

## Timing
- **Reset values:**
  - `instr_req_o` = 0, `instr_addr_o` = RESET_PC.
  - `out_valid_o` = 0, `out_inst_o` = 0, `out_pc_o` = 0, `out_err_o` = 0, `busy_o` = 0.
  - All counters = 0, `halted` = 0.
- `instr_req_o` may rise in the first cycle after `rst` deasserts.
- **Latency:** a kept `instr_rvalid_i` in cycle N gives `out_valid_o` in N+1 with that entry (no bypass).
- **Throughput:** with DEPTH ≥ MAX_OUTSTANDING+1, gnt and rvalid each cycle, and `out_ready_i` = 1, the buffer sustains one instruction per cycle.
- **Output decode:** `out_*` are driven combinationally from the FIFO head registers. They are stable while `out_valid_o` && !`out_ready_i`.
- **Flush cycle:** `out_valid_o` may still be high during the flush cycle, but the consumer's pop is ignored; in the following cycle `out_valid_o` = 0.
- **Reset mid-transaction:** all state is cleared asynchronously. The bus is assumed reset together with the block, so no response from before reset is received.

## Test plan
- **Streaming:** RESET_PC = 0x80, gnt and rvalid every cycle, ready = 1 → `out_pc_o` = 0x80, 0x84, 0x88…, one per cycle; outst never exceeds MAX_OUTSTANDING.
- **Back-pressure:** ready = 0, DEPTH = 4 → exactly 4 entries accepted, `instr_req_o` drops once count + outst = 4, and no response is lost. Release ready → entries 0x80..0x8C drain in order.
- **Flush with 2 outstanding:** flush to 0x1002 → next request addresses 0x1000; the 2 stale rvalids are dropped; first `out_pc_o` = 0x1000.
- **Flush while ungranted:** req at 0x90 held with gnt = 0; flush to 0x200 → addr stays 0x90 until gnt, that response is discarded, then the next request is 0x200.
- **Error:** rvalid+err on 0x84 → entry with pc 0x84, `out_err_o` = 1; no new requests issued; flush to 0x300 resumes fetching at 0x300.
- **Simultaneous events:** flush in the same cycle as gnt, rvalid and pop → discard = outst, FIFO empty next cycle, no stale entry ever appears at `out_valid_o`.

Source files
------------

// File: rtl/ifu_prefetch_buf.sv
// Instruction prefetch buffer between the fetch bus (req/gnt/rvalid) and decode.
// Keeps up to MAX_OUTSTANDING fetches in flight and up to DEPTH fetched words
// queued. Flush redirects fetching and drops stale responses; a kept bus error
// halts fetching until the next flush.
//
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   flush_i, flush_addr_i   : redirect request and target (bits [1:0] ignored)
//   instr_req_o/addr_o      : fetch request and word-aligned address
//   instr_gnt_i             : request accepted this cycle
//   instr_rvalid_i/rdata_i/err_i : in-order response, data, error
//   out_valid_o/ready_i     : FIFO head handshake toward decode
//   out_inst_o/pc_o/err_o   : head instruction, PC, bus-error marker
//   busy_o                  : fetches outstanding or stale responses pending
module ifu_prefetch_buf #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [31:0] out_pc_o,
    output logic        out_err_o,
    output logic        busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic             run_q;
    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [31:0]      redir_addr_q, redir_addr_d;
    logic             redir_pend_q, redir_pend_d;
    logic             req_pend_q, req_pend_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] inst_mem_q [DEPTH];
    logic [31:0] pc_mem_q   [DEPTH];
    logic        err_mem_q  [DEPTH];

    logic [SUM_W-1:0] credit_sum;
    logic             issue_ok;
    logic             req;
    logic             gnt;
    logic             keep;
    logic             pop;
    logic [31:0]      flush_tgt;

    // Issue credit: never request more than the FIFO can eventually hold.
    assign credit_sum = SUM_W'(count_q) + SUM_W'(outst_q);
    assign issue_ok   = !halted_q && (outst_q < CNT_W'(MAX_OUTSTANDING))
                        && (credit_sum < SUM_W'(DEPTH));
    // A raised request is held until granted, whatever else happens.
    assign req        = run_q && (req_pend_q || issue_ok);
    assign gnt        = req && instr_gnt_i;
    assign keep       = instr_rvalid_i && (discard_q == '0) && !flush_i;
    assign pop        = (count_q != '0) && out_ready_i && !flush_i;
    assign flush_tgt  = flush_addr_i & 32'hFFFF_FFFC;

    assign instr_req_o  = req;
    assign instr_addr_o = fetch_addr_q;
    assign out_valid_o  = (count_q != '0);
    assign out_inst_o   = inst_mem_q[rd_ptr_q];
    assign out_pc_o     = pc_mem_q[rd_ptr_q];
    assign out_err_o    = err_mem_q[rd_ptr_q];
    assign busy_o       = (outst_q != '0) || (discard_q != '0);

    // Next-state logic for fetch pointer, counters and FIFO bookkeeping.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        rsp_pc_d     = rsp_pc_q;
        redir_addr_d = redir_addr_q;
        redir_pend_d = redir_pend_q;
        halted_d     = halted_q;
        discard_d    = discard_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        req_pend_d   = req && !instr_gnt_i;
        outst_d      = outst_q + CNT_W'(gnt) - CNT_W'(instr_rvalid_i);

        if (flush_i) begin
            // Everything in flight, including a grant this cycle, is stale.
            discard_d = outst_d;
            halted_d  = 1'b0;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            rsp_pc_d  = flush_tgt;
            if (req && !instr_gnt_i) begin
                // Ungranted request must finish at its old address first.
                redir_pend_d = 1'b1;
                redir_addr_d = flush_tgt;
            end else begin
                redir_pend_d = 1'b0;
                fetch_addr_d = flush_tgt;
            end
        end else begin
            if (gnt) begin
                if (redir_pend_q) begin
                    fetch_addr_d = redir_addr_q;
                    redir_pend_d = 1'b0;
                end else begin
                    fetch_addr_d = fetch_addr_q + 32'd4;
                end
            end
            // The deferred request granted after a flush is also stale.
            discard_d = discard_q
                        - CNT_W'(instr_rvalid_i && (discard_q != '0))
                        + CNT_W'(gnt && redir_pend_q);
            if (keep) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (instr_err_i) begin
                    halted_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(keep) - CNT_W'(pop);
        end
    end

    // State and FIFO storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q        <= 1'b0;
            fetch_addr_q <= RESET_PC;
            rsp_pc_q     <= RESET_PC;
            redir_addr_q <= '0;
            redir_pend_q <= 1'b0;
            req_pend_q   <= 1'b0;
            halted_q     <= 1'b0;
            outst_q      <= '0;
            discard_q    <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
                err_mem_q[i]  <= 1'b0;
            end
        end else begin
            run_q        <= 1'b1;
            fetch_addr_q <= fetch_addr_d;
            rsp_pc_q     <= rsp_pc_d;
            redir_addr_q <= redir_addr_d;
            redir_pend_q <= redir_pend_d;
            req_pend_q   <= req_pend_d;
            halted_q     <= halted_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            if (keep) begin
                inst_mem_q[wr_ptr_q] <= instr_rdata_i;
                pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
                err_mem_q[wr_ptr_q]  <= instr_err_i;
            end
        end
    end

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
// Randomized bench for ifu_prefetch_buf: a bus agent answers granted fetches in
// order, and a transaction-level model (epoch-tagged in-flight list plus an
// expected-entry queue) predicts requests, addresses and the decode stream.
module tb_ifu_prefetch_buf;

    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0080;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [31:0] flush_addr_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_inst_o;
    logic [31:0] out_pc_o;
    logic        out_err_o;
    logic        busy_o;

    ifu_prefetch_buf #(
        .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush_i(flush_i),
        .flush_addr_i(flush_addr_i),
        .instr_req_o(instr_req_o),
        .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i),
        .instr_err_i(instr_err_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_inst_o(out_inst_o),
        .out_pc_o(out_pc_o),
        .out_err_o(out_err_o),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
        logic        err;
    } fl_t;

    ent_t        exp_q[$];
    fl_t         infl[$];
    int          epoch;
    int          req_epoch;
    logic [31:0] next_addr;
    logic [31:0] rsp_pc;
    logic [31:0] req_addr_m;
    bit          halted;
    bit          prev_req;
    bit          prev_gnt;
    int          cyc;
    int          n_vec;
    int          n_mis;
    bit          stream_win;
    int          pops;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        instr_err_i    = 1'b0;
        flush_i        = 1'b0;
        flush_addr_i   = '0;
        out_ready_i    = 1'b0;
        #1;
        chk("rst_req",   32'(instr_req_o), 32'd0);
        chk("rst_addr",  instr_addr_o, RESET_PC);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_inst",  out_inst_o, 32'd0);
        chk("rst_pc",    out_pc_o, 32'd0);
        chk("rst_err",   32'(out_err_o), 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        infl.delete();
        epoch      = 0;
        req_epoch  = 0;
        next_addr  = RESET_PC;
        rsp_pc     = RESET_PC;
        req_addr_m = RESET_PC;
        halted     = 1'b0;
        prev_req   = 1'b0;
        prev_gnt   = 1'b0;
        cyc        = 1;
    endtask

    // Compare this cycle's outputs with the model, then advance the model.
    task automatic model_step(input int p_err, input int dmin, input int dmax);
        bit          pending;
        bit          exp_req;
        logic [31:0] tgt;
        fl_t         f;
        ent_t        e;
        pending = prev_req && !prev_gnt;
        tgt     = flush_addr_i & 32'hFFFF_FFFC;

        if (pending) begin
            chk("req_hold",  32'(instr_req_o), 32'd1);
            chk("addr_hold", instr_addr_o, req_addr_m);
        end else begin
            exp_req = !halted && (infl.size() < MAXO) && ((exp_q.size() + infl.size()) < DEPTH);
            chk("req_issue", 32'(instr_req_o), 32'(exp_req));
            if (instr_req_o) begin
                chk("req_addr", instr_addr_o, next_addr);
                req_epoch  = epoch;
                req_addr_m = next_addr;
            end
        end

        chk("busy", 32'(busy_o), 32'(infl.size() != 0));
        chk("out_valid", 32'(out_valid_o), 32'(exp_q.size() != 0));
        if (out_valid_o && exp_q.size() != 0) begin
            chk("out_inst", out_inst_o, exp_q[0].inst);
            chk("out_pc",   out_pc_o,   exp_q[0].pc);
            chk("out_err",  32'(out_err_o), 32'(exp_q[0].err));
        end

        if (out_valid_o && out_ready_i && !flush_i) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (stream_win && cyc >= 10 && cyc < 50) pops++;
        end

        if (instr_rvalid_i && infl.size() != 0) begin
            f = infl.pop_front();
            if (!flush_i && f.epoch == epoch) begin
                e.inst = hash(rsp_pc);
                e.pc   = rsp_pc;
                e.err  = f.err;
                exp_q.push_back(e);
                if (f.err) halted = 1'b1;
                rsp_pc = rsp_pc + 32'd4;
            end
        end

        if (instr_req_o && instr_gnt_i) begin
            f.addr  = instr_addr_o;
            f.epoch = flush_i ? -1 : req_epoch;
            f.due   = cyc + int'($urandom_range(dmin, dmax));
            f.err   = ($urandom_range(0, 99) < p_err);
            infl.push_back(f);
            if (!flush_i && req_epoch == epoch) next_addr = req_addr_m + 32'd4;
        end

        if (flush_i) begin
            epoch++;
            exp_q.delete();
            halted    = 1'b0;
            rsp_pc    = tgt;
            next_addr = tgt;
        end

        prev_req = instr_req_o;
        prev_gnt = instr_gnt_i;
    endtask

    task automatic run_cycle(input int p_gnt, input int p_rv, input int dmin, input int dmax,
                             input int p_fl, input int p_rdy, input int p_err);
        @(posedge clk);
        #1;
        instr_gnt_i = instr_req_o && ($urandom_range(0, 99) < p_gnt);
        if (infl.size() != 0 && infl[0].due <= cyc && $urandom_range(0, 99) < p_rv) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = hash(infl[0].addr);
            instr_err_i    = infl[0].err;
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = $urandom;
            instr_err_i    = 1'($urandom_range(0, 1));
        end
        flush_i      = ($urandom_range(0, 99) < p_fl);
        flush_addr_i = $urandom;
        out_ready_i  = ($urandom_range(0, 99) < p_rdy);
        #4;
        model_step(p_err, dmin, dmax);
        cyc++;
    endtask

    initial begin
        n_vec      = 0;
        n_mis      = 0;
        pops       = 0;
        stream_win = 1'b0;
        cyc        = 0;
        rst        = 1'b0;
        #3;
        do_reset();

        // Streaming from RESET_PC: one instruction per cycle once filled.
        stream_win = 1'b1;
        for (int i = 0; i < 50; i++) run_cycle(100, 100, 1, 1, 0, 100, 0);
        stream_win = 1'b0;
        chk("stream_rate", 32'(pops), 32'd40);

        // Back-pressure then drain.
        for (int i = 0; i < 30; i++) run_cycle(100, 100, 1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) run_cycle(100, 100, 1, 2, 0, 100, 0);

        // Mixed random traffic with flushes and errors.
        for (int i = 0; i < 1500; i++) run_cycle(60, 60, 1, 3, 5, 70, 3);

        // Reset in the middle of traffic.
        do_reset();
        for (int i = 0; i < 1500; i++) run_cycle(30, 70, 1, 4, 10, 60, 6);

        // Dense events: flushes coinciding with grants, responses and pops.
        for (int i = 0; i < 800; i++) run_cycle(90, 90, 1, 1, 15, 90, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
